// File: rtl/replay_buffer_param.sv
// Parametrised data-link-layer replay buffer: stores transmitted TLPs with their sequence
// numbers, purges them on ACK and replays the outstanding ones as narrow beats on NAK or timeout.
module replay_buffer_param #(
    parameter int DIN_W  = 128,
    parameter int DOUT_W = 16,
    parameter int DEPTH  = 8,
    parameter int SEQ_W  = 12,
    parameter int RNUM_W = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       we,
    input  logic [DIN_W-1:0]           din,
    input  logic [SEQ_W-1:0]           seq,
    input  logic [1:0]                 ack_nack,
    input  logic [SEQ_W-1:0]           ack_seq,
    input  logic                       tim_out,
    input  logic                       busy_n,
    output logic                       ready,
    output logic [DOUT_W-1:0]          dout,
    output logic                       dout_valid,
    output logic                       dout_sop,
    output logic                       dout_eop,
    output logic                       replay_active,
    output logic                       retrain,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       ovf_err
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BEATS  = DIN_W / DOUT_W;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PURGE  = 2'd1,
        S_REPLAY = 2'd2
    } state_t;

    // An entry is acknowledged when ack_seq is at or ahead of it in modular sequence space.
    function automatic logic seq_covered(input logic [SEQ_W-1:0] ack_s, input logic [SEQ_W-1:0] head_s);
        logic [SEQ_W-1:0] diff_s;
        diff_s = ack_s - head_s;
        return ~diff_s[SEQ_W-1];
    endfunction

    logic [DIN_W-1:0]  data_mem [DEPTH];
    logic [SEQ_W-1:0]  seq_mem  [DEPTH];

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rp_ptr_q, rp_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d, rp_left_q, rp_left_d;
    logic [BEAT_W-1:0] rp_beat_q, rp_beat_d;
    logic [RNUM_W-1:0] rnum_q, rnum_d;
    logic [1:0]        pend_an_q, pend_an_d;
    logic [SEQ_W-1:0]  pend_seq_q, pend_seq_d, purge_seq_q, purge_seq_d;
    logic              pend_tim_q, pend_tim_d, purge_nak_q, purge_nak_d;
    logic [DOUT_W-1:0] dout_q, dout_d;
    logic              dout_valid_q, dout_valid_d, dout_sop_q, dout_sop_d, dout_eop_q, dout_eop_d;
    logic              retrain_q, retrain_d, ovf_err_q, ovf_err_d;

    logic              full_s, pend_any_s, ready_s, wr_en_s;
    logic [PTR_W-1:0]  nxt_ptr_s;
    logic [DIN_W-1:0]  cur_tlp_s;
    logic [DOUT_W-1:0] beat_s;
    logic [1:0]        eff_an_s;
    logic [SEQ_W-1:0]  eff_seq_s;
    logic              eff_tim_s, head_match_s, next_match_s, start_replay_s, load_s;

    assign full_s     = (count_q == CNT_W'(DEPTH));
    assign pend_any_s = (pend_an_q != 2'b00) || pend_tim_q;
    assign ready_s    = (state_q == S_IDLE) && !full_s && !pend_any_s;
    assign wr_en_s    = we && ready_s;
    assign nxt_ptr_s  = rd_ptr_q + PTR_W'(1);
    assign cur_tlp_s  = data_mem[rp_ptr_q];

    // Beat selection, most significant slice first.
    always_comb begin
        beat_s = {DOUT_W{1'b0}};
        for (int k = 0; k < BEATS; k++) begin
            if (rp_beat_q == BEAT_W'(k)) begin
                beat_s = cur_tlp_s[DIN_W-1-k*DOUT_W -: DOUT_W];
            end else begin
                beat_s = beat_s;
            end
        end
    end

    // Next-state and datapath for the IDLE / PURGE / REPLAY controller.
    always_comb begin
        state_d        = state_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        rp_ptr_d       = rp_ptr_q;
        rp_left_d      = rp_left_q;
        rp_beat_d      = rp_beat_q;
        rnum_d         = rnum_q;
        pend_an_d      = pend_an_q;
        pend_seq_d     = pend_seq_q;
        pend_tim_d     = pend_tim_q;
        purge_seq_d    = purge_seq_q;
        purge_nak_d    = purge_nak_q;
        dout_d         = dout_q;
        dout_valid_d   = dout_valid_q;
        dout_sop_d     = dout_sop_q;
        dout_eop_d     = dout_eop_q;
        retrain_d      = 1'b0;
        ovf_err_d      = ovf_err_q;
        eff_an_s       = 2'b00;
        eff_seq_s      = {SEQ_W{1'b0}};
        eff_tim_s      = 1'b0;
        head_match_s   = 1'b0;
        next_match_s   = 1'b0;
        start_replay_s = 1'b0;
        load_s         = 1'b0;

        if (wr_en_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            count_d  = count_q + CNT_W'(1);
        end else if (we) begin
            ovf_err_d = 1'b1;
        end else begin
            ovf_err_d = ovf_err_q;
        end

        // Requests arriving while busy wait in a one-deep holding register.
        if (state_q != S_IDLE) begin
            if (ack_nack == 2'b01 || ack_nack == 2'b10) begin
                pend_an_d  = ack_nack;
                pend_seq_d = ack_seq;
            end else begin
                pend_an_d  = pend_an_q;
            end
            pend_tim_d = pend_tim_q | tim_out;
        end else begin
            pend_tim_d = pend_tim_q;
        end

        case (state_q)
            S_IDLE: begin
                if (ack_nack == 2'b01 || ack_nack == 2'b10) begin
                    eff_an_s  = ack_nack;
                    eff_seq_s = ack_seq;
                end else begin
                    eff_an_s  = pend_an_q;
                    eff_seq_s = pend_seq_q;
                end
                eff_tim_s  = tim_out | pend_tim_q;
                pend_an_d  = 2'b00;
                pend_tim_d = 1'b0;
                if (eff_an_s == 2'b10) begin
                    state_d     = S_PURGE;
                    purge_seq_d = eff_seq_s;
                    purge_nak_d = 1'b1;
                end else if (eff_an_s == 2'b01) begin
                    // A timeout coinciding with an ACK is kept and served after the purge.
                    state_d     = S_PURGE;
                    purge_seq_d = eff_seq_s;
                    purge_nak_d = 1'b0;
                    pend_tim_d  = eff_tim_s;
                end else if (eff_tim_s && count_d != CNT_W'(0)) begin
                    start_replay_s = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PURGE: begin
                head_match_s = (count_q != CNT_W'(0)) && seq_covered(purge_seq_q, seq_mem[rd_ptr_q]);
                next_match_s = (count_q > CNT_W'(1)) && seq_covered(purge_seq_q, seq_mem[nxt_ptr_s]);
                if (head_match_s) begin
                    rd_ptr_d = nxt_ptr_s;
                    count_d  = count_q - CNT_W'(1);
                    rnum_d   = {RNUM_W{1'b0}};
                end else begin
                    rd_ptr_d = rd_ptr_q;
                end
                // Look one entry ahead so the exit happens on the cycle of the last purge.
                if (head_match_s && next_match_s) begin
                    state_d = S_PURGE;
                end else if (purge_nak_q && count_d != CNT_W'(0)) begin
                    start_replay_s = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REPLAY: begin
                load_s = !dout_valid_q || busy_n;
                if (!load_s) begin
                    dout_valid_d = dout_valid_q;
                end else if (rp_left_q != CNT_W'(0)) begin
                    dout_d       = beat_s;
                    dout_valid_d = 1'b1;
                    dout_sop_d   = (rp_beat_q == BEAT_W'(0));
                    dout_eop_d   = (rp_beat_q == BEAT_W'(BEATS-1));
                    if (rp_beat_q == BEAT_W'(BEATS-1)) begin
                        rp_beat_d = BEAT_W'(0);
                        rp_ptr_d  = rp_ptr_q + PTR_W'(1);
                        rp_left_d = rp_left_q - CNT_W'(1);
                    end else begin
                        rp_beat_d = rp_beat_q + BEAT_W'(1);
                    end
                end else begin
                    dout_d       = {DOUT_W{1'b0}};
                    dout_valid_d = 1'b0;
                    dout_sop_d   = 1'b0;
                    dout_eop_d   = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (start_replay_s) begin
            state_d   = S_REPLAY;
            rp_ptr_d  = rd_ptr_d;
            rp_left_d = count_d;
            rp_beat_d = BEAT_W'(0);
            retrain_d = (rnum_d == {RNUM_W{1'b1}});
            rnum_d    = rnum_d + RNUM_W'(1);
        end else begin
            retrain_d = 1'b0;
        end
    end

    // Control and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= {PTR_W{1'b0}};
            rd_ptr_q     <= {PTR_W{1'b0}};
            count_q      <= {CNT_W{1'b0}};
            rp_ptr_q     <= {PTR_W{1'b0}};
            rp_left_q    <= {CNT_W{1'b0}};
            rp_beat_q    <= {BEAT_W{1'b0}};
            rnum_q       <= {RNUM_W{1'b0}};
            pend_an_q    <= 2'b00;
            pend_seq_q   <= {SEQ_W{1'b0}};
            pend_tim_q   <= 1'b0;
            purge_seq_q  <= {SEQ_W{1'b0}};
            purge_nak_q  <= 1'b0;
            dout_q       <= {DOUT_W{1'b0}};
            dout_valid_q <= 1'b0;
            dout_sop_q   <= 1'b0;
            dout_eop_q   <= 1'b0;
            retrain_q    <= 1'b0;
            ovf_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            rp_ptr_q     <= rp_ptr_d;
            rp_left_q    <= rp_left_d;
            rp_beat_q    <= rp_beat_d;
            rnum_q       <= rnum_d;
            pend_an_q    <= pend_an_d;
            pend_seq_q   <= pend_seq_d;
            pend_tim_q   <= pend_tim_d;
            purge_seq_q  <= purge_seq_d;
            purge_nak_q  <= purge_nak_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            dout_sop_q   <= dout_sop_d;
            dout_eop_q   <= dout_eop_d;
            retrain_q    <= retrain_d;
            ovf_err_q    <= ovf_err_d;
        end
    end

    // Slot storage; contents are meaningless once the pointers are reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            data_mem[wr_ptr_q] <= din;
            seq_mem[wr_ptr_q]  <= seq;
        end
    end

    assign ready         = ready_s;
    assign dout          = dout_q;
    assign dout_valid    = dout_valid_q;
    assign dout_sop      = dout_sop_q;
    assign dout_eop      = dout_eop_q;
    assign replay_active = (state_q == S_REPLAY);
    assign retrain       = retrain_q;
    assign count         = count_q;
    assign ovf_err       = ovf_err_q;

endmodule

// File: tb/tb_replay_buffer_param.sv
// Self-checking bench for replay_buffer_param: write table plus a beat scoreboard filled
// from a reference model of the stored TLPs whenever a replay is requested.
module tb_replay_buffer_param;

    logic         clk = 1'b0;
    logic         reset_n, we, tim_out, busy_n;
    logic [127:0] din;
    logic [11:0]  seq, ack_seq;
    logic [1:0]   ack_nack;
    logic         ready, dout_valid, dout_sop, dout_eop, replay_active, retrain, ovf_err;
    logic [15:0]  dout;
    logic [3:0]   count;

    typedef struct { logic [127:0] din; logic [11:0] seq; logic [3:0] exp_count; } wvec_t;
    typedef struct { logic [15:0] data; logic sop; logic eop; } beat_t;

    wvec_t        wtab [8];
    beat_t        exp_q [$];
    logic [127:0] m_din [$];
    logic [11:0]  m_seq [$];
    int           n_checks = 0;
    int           n_fail = 0;
    int           beats_seen = 0;

    replay_buffer_param dut (
        .clk(clk), .reset_n(reset_n), .we(we), .din(din), .seq(seq),
        .ack_nack(ack_nack), .ack_seq(ack_seq), .tim_out(tim_out), .busy_n(busy_n),
        .ready(ready), .dout(dout), .dout_valid(dout_valid), .dout_sop(dout_sop),
        .dout_eop(dout_eop), .replay_active(replay_active), .retrain(retrain),
        .count(count), .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit covered(input logic [11:0] a, input logic [11:0] h);
        int d;
        d = (int'(a) - int'(h) + 4096) % 4096;
        return d < 2048;
    endfunction

    task automatic model_purge(input logic [11:0] a);
        while (m_seq.size() > 0 && covered(a, m_seq[0])) begin
            void'(m_seq.pop_front());
            void'(m_din.pop_front());
        end
    endtask

    task automatic push_replay();
        beat_t        b;
        logic [127:0] t;
        for (int i = 0; i < m_din.size(); i++) begin
            for (int k = 0; k < 8; k++) begin
                t = m_din[i] >> (128 - 16 * (k + 1));
                b.data = t[15:0];
                b.sop  = (k == 0);
                b.eop  = (k == 7);
                exp_q.push_back(b);
            end
        end
    endtask

    // One clock: score any beat transferring this cycle, then advance to just after the edge.
    task automatic cyc();
        beat_t e;
        if (reset_n && dout_valid && busy_n) begin
            beats_seen++;
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 128'd1, 128'd0);
            end else begin
                e = exp_q.pop_front();
                check("beat_data", dout, e.data);
                check("beat_sop", dout_sop, e.sop);
                check("beat_eop", dout_eop, e.eop);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_quiet(input int limit);
        int i;
        i = 0;
        while (!(ready && !replay_active && exp_q.size() == 0) && i < limit) begin
            cyc();
            i++;
        end
        check("quiet_timeout", (ready && exp_q.size() == 0), 128'd1);
    endtask

    task automatic do_reset();
        reset_n = 1'b0; we = 1'b0; ack_nack = 2'b00; tim_out = 1'b0; busy_n = 1'b1;
        exp_q.delete(); m_din.delete(); m_seq.delete();
        cyc();
        reset_n = 1'b1;
    endtask

    task automatic write(input logic [127:0] d, input logic [11:0] s);
        we = 1'b1; din = d; seq = s;
        m_din.push_back(d); m_seq.push_back(s);
        cyc();
        we = 1'b0;
    endtask

    task automatic issue(input logic [1:0] an, input logic [11:0] s);
        ack_nack = an; ack_seq = s;
        cyc();
        ack_nack = 2'b00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pc;
        for (int i = 0; i < 8; i++) begin
            wtab[i].seq = 12'(i);
            wtab[i].exp_count = 4'(i + 1);
            for (int k = 0; k < 8; k++) wtab[i].din[127-16*k -: 16] = 16'((i << 8) | (k * 17) | 16'hA000);
        end
        wtab[0].din = 128'h400000010000000ffdaff04012345678;
        din = 128'd0; seq = 12'd0; ack_seq = 12'd0;

        // Reset state
        do_reset();
        check("rst_ready", ready, 1); check("rst_count", count, 0); check("rst_valid", dout_valid, 0);
        check("rst_active", replay_active, 0); check("rst_retrain", retrain, 0);
        check("rst_ovf", ovf_err, 0); check("rst_dout", dout, 0);

        // Three writes from the table
        for (int i = 0; i < 3; i++) begin
            write(wtab[i].din, wtab[i].seq);
            check("wr_count", count, wtab[i].exp_count);
            check("wr_ready", ready, 1);
            check("wr_valid", dout_valid, 0);
        end

        // ACK seq 1: two purge cycles, one entry left, no beats
        model_purge(12'd1);
        issue(2'b01, 12'd1);
        pc = 0;
        while (!ready && pc < 20) begin pc++; cyc(); end
        check("purge_cycles", pc, 2);
        check("ack_count", count, m_seq.size());

        // NAK seq 0 with 0..2 held: seq0 purged, seq1/seq2 replayed
        do_reset();
        for (int i = 0; i < 3; i++) write(wtab[i].din, wtab[i].seq);
        model_purge(12'd0);
        push_replay();
        beats_seen = 0;
        issue(2'b10, 12'd0);
        wait_quiet(100);
        check("nak_beats", beats_seen, 16);
        check("nak_count", count, 2);

        // Four timeouts: retrain on the fourth; stall mid-TLP during the second
        do_reset();
        for (int i = 0; i < 2; i++) write(wtab[i + 3].din, wtab[i + 3].seq);
        for (int r = 0; r < 4; r++) begin
            push_replay();
            beats_seen = 0;
            tim_out = 1'b1;
            cyc();
            tim_out = 1'b0;
            check("to_retrain", retrain, (r == 3));
            check("to_active", replay_active, 1);
            check("to_first_valid", dout_valid, 0);
            cyc();
            check("to_second_valid", dout_valid, 1);
            check("to_second_sop", dout_sop, 1);
            if (r == 1) begin
                pc = 0;
                while (beats_seen < 3 && pc < 20) begin pc++; cyc(); end
                busy_n = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    cyc();
                    check("stall_valid", dout_valid, 1);
                    check("stall_data", dout, exp_q[0].data);
                end
                busy_n = 1'b1;
            end
            wait_quiet(100);
            check("to_beats", beats_seen, 16);
        end

        // Fill to full, overflow, sequence wrap purge, NAK on empty
        do_reset();
        for (int i = 0; i < 8; i++) begin
            write(wtab[i].din, wtab[i].seq);
            check("fill_count", count, wtab[i].exp_count);
            check("fill_ready", ready, (i < 7));
        end
        we = 1'b1; din = 128'hDEAD; seq = 12'd8;
        cyc();
        we = 1'b0;
        check("ovf_err", ovf_err, 1);
        check("ovf_count", count, 8);
        do_reset();
        check("ovf_cleared", ovf_err, 0);
        write(wtab[5].din, 12'd4094);
        write(wtab[6].din, 12'd4095);
        write(wtab[7].din, 12'd0);
        model_purge(12'd0);
        issue(2'b01, 12'd0);
        wait_quiet(20);
        check("wrap_count", count, m_seq.size());
        issue(2'b10, 12'd5);
        check("nak_empty_busy", ready, 0);
        cyc();
        check("nak_empty_ready", ready, 1);
        check("nak_empty_count", count, 0);

        // ACK during replay is held until the replay ends
        do_reset();
        write(wtab[1].din, 12'd5);
        write(wtab[2].din, 12'd6);
        push_replay();
        tim_out = 1'b1;
        cyc();
        tim_out = 1'b0;
        for (int i = 0; i < 4; i++) cyc();
        issue(2'b01, 12'd5);
        check("pend_count_held", count, 2);
        pc = 0;
        while (replay_active && pc < 50) begin pc++; cyc(); end
        check("pend_idle_ready", ready, 0);
        check("pend_idle_valid", dout_valid, 0);
        model_purge(12'd5);
        wait_quiet(20);
        check("pend_count", count, m_seq.size());

        // Reset in the middle of a replay
        push_replay();
        tim_out = 1'b1;
        cyc();
        tim_out = 1'b0;
        for (int i = 0; i < 4; i++) cyc();
        check("mid_active", replay_active, 1);
        reset_n = 1'b0;
        exp_q.delete();
        cyc();
        reset_n = 1'b1;
        check("mid_rst_count", count, 0);
        check("mid_rst_valid", dout_valid, 0);
        check("mid_rst_ready", ready, 1);
        check("mid_rst_active", replay_active, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
